// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Shares the single write port of the register file among N requesters
// (ALU writeback, load unit, PC-link path, ...). Requests are arbitrated
// round-robin. The winner receives a one-cycle registered grant pulse. Its
// address and data are captured and written to the register file with a
// registered write strobe in the following cycle. A transaction therefore
// always takes two cycles: GRANT, then WRITE. Back-to-back transactions
// alternate GRANT/WRITE with no idle cycle in between.
//
// Parameters
//   N   number of requesters (2..8)
//   AW  register address width
//   DW  register data width
//
// Ports
//   CLK    in   system clock, all state changes on the rising edge
//   RST    in   synchronous active-high reset
//   REQ    in   [N]     level request per requester
//   ADDR   in   [N*AW]  packed write addresses, requester i at [i*AW +: AW]
//   DATA   in   [N*DW]  packed write data, requester i at [i*DW +: DW]
//   GNT    out  [N]     one-hot grant pulse (registered)
//   WE     out          register file write enable (registered)
//   WADDR  out  [AW]    register file write address (registered)
//   WDATA  out  [DW]    register file write data (registered)
//   BUSY   out          high while a transaction is in flight (GRANT/WRITE)
//
// Build option
//   ARB_ZERO_REG_GUARD_EN  when defined, a transaction that targets register 0
//                          still runs through GRANT and WRITE with a normal
//                          grant pulse, but WE is suppressed. Register 0 then
//                          stays hardwired to zero.
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int N  = 4,
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    REQ,
  input  logic [N*AW-1:0] ADDR,
  input  logic [N*DW-1:0] DATA,
  output logic [N-1:0]    GNT,
  output logic            WE,
  output logic [AW-1:0]   WADDR,
  output logic [DW-1:0]   WDATA,
  output logic            BUSY
);

  // Pointer width, plus one spare bit so that ptr + offset never overflows
  // before the modulo-N correction.
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] ptr_after_win;

  logic [SW-1:0] search_idx;
  logic [PW-1:0] win;
  logic          win_found;
  logic          arbitrate;

  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  logic [N-1:0]  gnt_next;
  logic          we_next;
  logic [AW-1:0] waddr_next;
  logic [DW-1:0] wdata_next;

  // Round-robin search: walk upward from the pointer, modulo N, and take the
  // first active request. The search index is recomputed on every iteration,
  // so it never carries a value between evaluations.
  always_comb begin
    win        = '0;
    win_found  = 1'b0;
    search_idx = '0;
    for (int k = 0; k < N; k++) begin
      search_idx = {1'b0, ptr} + SW'(k);
      if (search_idx >= SW'(N)) begin
        search_idx = search_idx - SW'(N);
      end
      if (!win_found && REQ[search_idx[PW-1:0]]) begin
        win_found = 1'b1;
        win       = search_idx[PW-1:0];
      end
    end
  end

  // Pick out the winner's address and data from the packed buses. Comparing
  // against each constant index keeps the part-selects static.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win == PW'(i)) begin
        win_addr = ADDR[i*AW +: AW];
        win_data = DATA[i*DW +: DW];
      end
    end
  end

  // The pointer moves to the requester just after the winner and wraps
  // from N-1 back to 0.
  always_comb begin
    if (win == PW'(N - 1)) begin
      ptr_after_win = '0;
    end else begin
      ptr_after_win = win + PW'(1);
    end
  end

  // Arbitration only happens on edges leaving IDLE or WRITE. Requests seen
  // during GRANT are ignored, because the requester is still holding the
  // request it was just granted.
  assign arbitrate = ((state == IDLE) || (state == WRITE)) && win_found;

  // State register. It also holds the pointer and all registered outputs,
  // so every output changes only on the clock edge. Reset drops any
  // in-flight transaction, so a write pending in GRANT never gets WE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      GNT   <= '0;
      WE    <= 1'b0;
      WADDR <= '0;
      WDATA <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      GNT   <= gnt_next;
      WE    <= we_next;
      WADDR <= waddr_next;
      WDATA <= wdata_next;
    end
  end

  // Next-state logic. GRANT always lasts exactly one cycle. WRITE either
  // chains directly into the next GRANT or falls back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = win_found ? GRANT : IDLE;
      GRANT:   state_next = WRITE;
      WRITE:   state_next = win_found ? GRANT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The values for the next cycle are built here and then
  // registered above. WADDR/WDATA keep their value until the next capture,
  // so the register file sees stable operands throughout WRITE.
  always_comb begin
    gnt_next   = '0;
    we_next    = 1'b0;
    waddr_next = WADDR;
    wdata_next = WDATA;
    ptr_next   = ptr;

    if (arbitrate) begin
      gnt_next   = N'(1) << win;
      waddr_next = win_addr;
      wdata_next = win_data;
      ptr_next   = ptr_after_win;
    end

`ifdef ARB_ZERO_REG_GUARD_EN
    // Register 0 is hardwired to zero: the transaction still runs, but the
    // write strobe is suppressed.
    we_next = (state == GRANT) && (WADDR != '0);
`else
    we_next = (state == GRANT);
`endif

    BUSY = (state == GRANT) || (state == WRITE);
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Self-checking bench for reg_write_arbiter (N=4, AW=3, DW=8). Directed
// scenarios check against constants. A randomized scenario checks every
// cycle against a transaction-level reference model kept in this file.
// Define ARB_ZERO_REG_GUARD_EN for both bench and design to check the
// register-0 guard.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 8;

`ifdef ARB_ZERO_REG_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            CLK;
  logic            RST;
  logic [N-1:0]    REQ;
  logic [N*AW-1:0] ADDR;
  logic [N*DW-1:0] DATA;
  logic [N-1:0]    GNT;
  logic            WE;
  logic [AW-1:0]   WADDR;
  logic [DW-1:0]   WDATA;
  logic            BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-requester operands presented on the packed buses.
  logic [AW-1:0] a_arr [N];
  logic [DW-1:0] d_arr [N];

  // Reference model. m_phase: 0 = idle, 1 = granted, 2 = writing.
  int            m_phase = 0;
  int            m_ptr   = 0;
  logic [N-1:0]  m_gnt   = '0;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_waddr = '0;
  logic [DW-1:0] m_wdata = '0;

  reg_write_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .ADDR  (ADDR),
    .DATA  (DATA),
    .GNT   (GNT),
    .WE    (WE),
    .WADDR (WADDR),
    .WDATA (WDATA),
    .BUSY  (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Transaction-level model, updated once per rising edge using the inputs
  // that were sampled at that edge.
  task automatic model_step(input logic rst, input logic [N-1:0] req);
    int found;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_gnt = '0; m_we = 1'b0;
      m_waddr = '0; m_wdata = '0;
    end else if (m_phase == 1) begin
      m_phase = 2;
      m_gnt   = '0;
      m_we    = GUARD ? (m_waddr != 0) : 1'b1;
    end else begin
      m_gnt = '0;
      m_we  = 1'b0;
      found = -1;
      for (int k = 0; k < N; k++) begin
        if (found < 0 && req[(m_ptr + k) % N]) found = (m_ptr + k) % N;
      end
      if (found >= 0) begin
        m_gnt[found] = 1'b1;
        m_waddr      = a_arr[found];
        m_wdata      = d_arr[found];
        m_ptr        = (found + 1) % N;
        m_phase      = 1;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  // Drive inputs, pass one rising edge, advance the model, then return at
  // the falling edge where outputs are sampled.
  task automatic tick(input logic rst, input logic [N-1:0] req);
    RST = rst;
    REQ = req;
    for (int i = 0; i < N; i++) begin
      ADDR[i*AW +: AW] = a_arr[i];
      DATA[i*DW +: DW] = d_arr[i];
    end
    @(posedge CLK);
    model_step(rst, req);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    tick(1'b1, '0);
    tick(1'b1, '0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = AW'($urandom);
      d_arr[i] = DW'($urandom);
    end
    for (int c = 0; c < 2; c++) begin
      tick(1'b1, 4'b1111);
      n_checks++;
      if ({GNT, WE, WADDR, WDATA, BUSY} !== '0) begin
        n_fail++;
        $display("FAIL reset_zero cyc%0d: got GNT=%b WE=%b WADDR=%h WDATA=%h BUSY=%b, expected all 0",
                 c, GNT, WE, WADDR, WDATA, BUSY);
      end
    end
    tick(1'b0, 4'b1111);
    n_checks++;
    if (GNT !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b expected 0001", GNT);
    end
    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0000);
  endtask

  task automatic test_single();
    do_reset();
    a_arr[2] = 3'd5;
    d_arr[2] = 8'hA7;
    tick(1'b0, 4'b0100);
    n_checks++;
    if (GNT !== 4'b0100 || WE !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got GNT=%b WE=%b BUSY=%b expected 0100/0/1", GNT, WE, BUSY);
    end
    tick(1'b0, 4'b0000);
    n_checks++;
    if (WE !== 1'b1 || WADDR !== 3'd5 || WDATA !== 8'hA7 || GNT !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_write: got WE=%b WADDR=%0d WDATA=%h GNT=%b expected 1/5/a7/0000",
               WE, WADDR, WDATA, GNT);
    end
    tick(1'b0, 4'b0000);
    n_checks++;
    if (BUSY !== 1'b0 || WE !== 1'b0 || WADDR !== 3'd5) begin
      n_fail++;
      $display("FAIL single_idle: got BUSY=%b WE=%b WADDR=%0d expected 0/0/5", BUSY, WE, WADDR);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_gnt;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      exp_gnt = '0;
      exp_gnt[order[g]] = 1'b1;
      tick(1'b0, 4'b1111);
      n_checks++;
      if (GNT !== exp_gnt || WE !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got GNT=%b WE=%b expected %b/0", g, GNT, WE, exp_gnt);
      end
      tick(1'b0, 4'b1111);
      n_checks++;
      if (GNT !== 4'b0000 || WE !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_write%0d: got GNT=%b WE=%b expected 0000/1", g, GNT, WE);
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    // A single grant to requester 2 leaves the pointer at 3.
    tick(1'b0, 4'b0100);
    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0011);
    n_checks++;
    if (GNT !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_first: got %b expected 0001", GNT);
    end
    tick(1'b0, 4'b0010);
    tick(1'b0, 4'b0010);
    n_checks++;
    if (GNT !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_second: got %b expected 0010", GNT);
    end
    tick(1'b0, 4'b0000);
    tick(1'b0, 4'b0000);
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_arr[0] = 3'd6;
    d_arr[0] = 8'h3C;
    tick(1'b0, 4'b0001);
    n_checks++;
    if (GNT !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_grant: got %b expected 0001", GNT);
    end
    tick(1'b1, 4'b0001);
    n_checks++;
    if ({GNT, WE, WADDR, WDATA, BUSY} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got GNT=%b WE=%b WADDR=%h WDATA=%h BUSY=%b expected all 0",
               GNT, WE, WADDR, WDATA, BUSY);
    end
    tick(1'b0, 4'b0000);
    n_checks++;
    if (WE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_write: got WE=%b BUSY=%b expected 0/0", WE, BUSY);
    end
  endtask

  task automatic test_zero_guard();
    do_reset();
    a_arr[1] = 3'd0;
    d_arr[1] = 8'hFF;
    tick(1'b0, 4'b0010);
    n_checks++;
    if (GNT !== 4'b0010) begin
      n_fail++;
      $display("FAIL zero_grant: got %b expected 0010", GNT);
    end
    tick(1'b0, 4'b0000);
    n_checks++;
    if (WE !== !GUARD || WADDR !== 3'd0 || WDATA !== 8'hFF || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_write: got WE=%b WADDR=%0d WDATA=%h BUSY=%b expected %b/0/ff/1",
               WE, WADDR, WDATA, BUSY, !GUARD);
    end
    tick(1'b0, 4'b0000);
  endtask

  task automatic test_random();
    logic [N-1:0] req;
    logic         rst;
    do_reset();
    req = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_gnt[i]) begin
          // Granted: drop the request unless another write is wanted.
          req[i] = ($urandom_range(0, 3) == 0);
          if (req[i]) begin
            a_arr[i] = AW'($urandom);
            d_arr[i] = DW'($urandom);
          end
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 2) == 0);
          if (req[i]) begin
            a_arr[i] = AW'($urandom);
            d_arr[i] = DW'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
      rst = ($urandom_range(0, 59) == 0);
      tick(rst, req);
      n_checks++;
      if (GNT !== m_gnt || WE !== m_we) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc%0d: got GNT=%b WE=%b expected %b/%b", c, GNT, WE, m_gnt, m_we);
      end
      n_checks++;
      if (WADDR !== m_waddr || WDATA !== m_wdata) begin
        n_fail++;
        $display("FAIL rand_data cyc%0d: got WADDR=%h WDATA=%h expected %h/%h",
                 c, WADDR, WDATA, m_waddr, m_wdata);
      end
      n_checks++;
      if (BUSY !== (m_phase != 0)) begin
        n_fail++;
        $display("FAIL rand_busy cyc%0d: got %b expected %b", c, BUSY, (m_phase != 0));
      end
    end
  endtask

  initial begin
    RST  = 1'b1;
    REQ  = '0;
    ADDR = '0;
    DATA = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      d_arr[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_reset_mid();
    test_zero_guard();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
